// File: rtl/opl3_host_wr_bridge_if.sv
// -----------------------------------------------------------------------------
// opl3_host_wr_bridge_if
//
// Shared types and the bus interface for the OPL3 host write bridge.
//
// opl3_host_wr_bridge_pkg
//   opl3_reg_wr_t : {valid, bank_num[0:0], address[7:0], data[7:0]}, the
//                   register write handed to the downstream register file.
//
// opl3_host_wr_bridge_if signals
//   host_valid  : host access strobe, one access per cycle when high
//   host_addr   : port select (0 bank0 addr, 1 data, 2 bank1 addr, 3 data)
//   host_data   : address or data byte
//   host_ready  : a data access presented now will be accepted
//   overflow    : sticky, a data-port access was dropped
//   opl3_reg_wr : single-cycle register write pulse to downstream
//
// Modports
//   master : host side (drives the access, observes ready/overflow/writes)
//   slave  : bridge side
// -----------------------------------------------------------------------------
package opl3_host_wr_bridge_pkg;

    typedef struct packed {
        logic       valid;
        logic [0:0] bank_num;
        logic [7:0] address;
        logic [7:0] data;
    } opl3_reg_wr_t;

endpackage

interface opl3_host_wr_bridge_if;
    import opl3_host_wr_bridge_pkg::*;

    logic         host_valid;
    logic [1:0]   host_addr;
    logic [7:0]   host_data;
    logic         host_ready;
    logic         overflow;
    opl3_reg_wr_t opl3_reg_wr;

    modport master (
        output host_valid, host_addr, host_data,
        input  host_ready, overflow, opl3_reg_wr
    );

    modport slave (
        input  host_valid, host_addr, host_data,
        output host_ready, overflow, opl3_reg_wr
    );

endinterface

// File: rtl/opl3_host_wr_bridge.sv
// -----------------------------------------------------------------------------
// opl3_host_wr_bridge
//
// Turns host accesses on the classic 4-port OPL3 map into a paced stream of
// single-cycle register writes. Address-port accesses update an address/bank
// latch; data-port accesses push {bank, address, data} into a small FIFO. A
// drain FSM replays the FIFO as opl3_reg_wr pulses at least MIN_WR_GAP clocks
// apart, back-to-back at exactly MIN_WR_GAP while the FIFO stays non-empty.
//
// Parameters
//   FIFO_DEPTH : buffered register writes (power of two, >= 2)
//   MIN_WR_GAP : minimum clocks between opl3_reg_wr.valid pulses (>= 1)
//
// Ports
//   clk        : system clock
//   reset      : asynchronous, active-high reset
//   bus        : opl3_host_wr_bridge_if.slave (host access, host_ready,
//                overflow, opl3_reg_wr)
//   wr_count   : (stats build) pulses issued, wraps at 0xFFFF
//   drop_count : (stats build) dropped data writes, saturates at 0xFF
//
// Optional feature: define OPL3_HOST_WR_BRIDGE_STATS_EN to add the wr_count
// and drop_count outputs. Without it, behaviour is otherwise identical.
// -----------------------------------------------------------------------------
module opl3_host_wr_bridge
    import opl3_host_wr_bridge_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned MIN_WR_GAP = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    opl3_host_wr_bridge_if.slave      bus
`ifdef OPL3_HOST_WR_BRIDGE_STATS_EN
    ,
    output logic [15:0]               wr_count,
    output logic [7:0]                drop_count
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = (MIN_WR_GAP > 2) ? $clog2(MIN_WR_GAP) : 1;
    // GAP is entered for MIN_WR_GAP-1 cycles; the counter counts down to 0.
    localparam logic [GW-1:0] GAP_INIT = GW'((MIN_WR_GAP > 1) ? MIN_WR_GAP - 2 : 0);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef struct packed {
        logic [0:0] bank;
        logic [7:0] addr;
        logic [7:0] data;
    } entry_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_GAP
    } state_e;

    // Address latch
    logic [0:0]   bank_q;
    logic [7:0]   addr_q;

    // FIFO
    entry_t       mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Flags and output
    logic         host_ready_q;
    logic         overflow_q;
    opl3_reg_wr_t out_q;
    opl3_reg_wr_t out_d;

    // Drain FSM
    state_e       state_q;
    state_e       state_d;
    logic [GW-1:0] gap_q;
    logic [GW-1:0] gap_d;

    logic addr_wr;
    logic data_wr;
    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic pop;
    logic drop;
    entry_t head;

    assign addr_wr    = bus.host_valid & ~bus.host_addr[0];
    assign data_wr    = bus.host_valid &  bus.host_addr[0];
    // Full is taken from the registered occupancy, i.e. before any pop in
    // the same cycle, so a push into a full FIFO is dropped even if a pop
    // happens alongside it.
    assign fifo_full  = (count_q == FULL_CNT);
    assign fifo_empty = (count_q == '0);
    assign push       = data_wr & ~fifo_full;
    assign drop       = data_wr &  fifo_full;
    assign head       = mem_q[rd_ptr_q];

    // The output register is loaded on the edge that enters ISSUE, so the
    // pulse is registered and the pop coincides with that edge; the pulse is
    // therefore visible exactly while state_q == S_ISSUE.
    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_d     = state_q;
        gap_d       = gap_q;
        out_d       = out_q;
        out_d.valid = 1'b0;
        pop         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (MIN_WR_GAP > 1) begin
                    state_d = S_GAP;
                    gap_d   = GAP_INIT;
                end else if (!fifo_empty) begin
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GAP: begin
                if (gap_q == '0) begin
                    state_d = fifo_empty ? S_IDLE : S_ISSUE;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_ISSUE) begin
            pop              = 1'b1;
            out_d.valid      = 1'b1;
            out_d.bank_num   = head.bank;
            out_d.address    = head.addr;
            out_d.data       = head.data;
        end
    end

    assign count_d = count_q + CW'(push) - CW'(pop);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bank_q       <= '0;
            addr_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            host_ready_q <= 1'b0;
            overflow_q   <= 1'b0;
            out_q        <= '0;
            state_q      <= S_IDLE;
            gap_q        <= '0;
        end else begin
            if (addr_wr) begin
                bank_q <= bus.host_addr[1:1];
                addr_q <= bus.host_data;
            end
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q      <= count_d;
            host_ready_q <= (count_d != FULL_CNT);
            if (drop) overflow_q <= 1'b1;
            out_q        <= out_d;
            state_q      <= state_d;
            gap_q        <= gap_d;
        end
    end

    // NOTE: FIFO storage has no reset; occupancy and pointers alone decide
    // which entries are meaningful, so clearing the array buys nothing.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= '{bank: bank_q, addr: addr_q, data: bus.host_data};
    end

    assign bus.host_ready  = host_ready_q;
    assign bus.overflow    = overflow_q;
    assign bus.opl3_reg_wr = out_q;

`ifdef OPL3_HOST_WR_BRIDGE_STATS_EN
    logic [15:0] wr_count_q;
    logic [7:0]  drop_count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_count_q   <= '0;
            drop_count_q <= '0;
        end else begin
            if (out_q.valid) wr_count_q <= wr_count_q + 16'd1;
            if (drop && (drop_count_q != 8'hFF)) drop_count_q <= drop_count_q + 8'd1;
        end
    end

    assign wr_count   = wr_count_q;
    assign drop_count = drop_count_q;
`endif

endmodule

// File: tb/tb_opl3_host_wr_bridge.sv
// -----------------------------------------------------------------------------
// tb_opl3_host_wr_bridge
//
// Directed bench for opl3_host_wr_bridge. One instance uses the default
// parameters (FIFO_DEPTH=8, MIN_WR_GAP=4); a second uses MIN_WR_GAP=1 for
// the back-to-back case. Expected writes go into a scoreboard queue as
// stimulus is driven; monitors record every observed pulse with its cycle
// number, and the directed sequence compares the two.
// -----------------------------------------------------------------------------
module tb_opl3_host_wr_bridge;
    import opl3_host_wr_bridge_pkg::*;

    typedef struct packed {
        logic [0:0] bank;
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    typedef struct {
        logic [0:0] bank;
        logic [7:0] addr;
        logic [7:0] data;
        int         cyc;
    } pulse_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    opl3_host_wr_bridge_if bus ();
    opl3_host_wr_bridge_if bus1 ();

`ifdef OPL3_HOST_WR_BRIDGE_STATS_EN
    logic [15:0] wr_count;
    logic [7:0]  drop_count;
    logic [15:0] wr_count1;
    logic [7:0]  drop_count1;
`endif

    opl3_host_wr_bridge #(.FIFO_DEPTH(8), .MIN_WR_GAP(4)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus)
`ifdef OPL3_HOST_WR_BRIDGE_STATS_EN
        ,
        .wr_count   (wr_count),
        .drop_count (drop_count)
`endif
    );

    opl3_host_wr_bridge #(.FIFO_DEPTH(8), .MIN_WR_GAP(1)) u_dut1 (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus1)
`ifdef OPL3_HOST_WR_BRIDGE_STATS_EN
        ,
        .wr_count   (wr_count1),
        .drop_count (drop_count1)
`endif
    );

    // Scoreboard and observation queues
    wr_t    exp_q[$];
    int     exp_rd = 0;
    pulse_t obs_q[$];
    int     obs_rd = 0;
    pulse_t obs1_q[$];
    int     obs1_rd = 0;
    int     pc_q[$];

    int total = 0;
    int bad   = 0;

    always @(negedge clk) begin
        pulse_t p;
        if (bus.opl3_reg_wr.valid === 1'b1) begin
            p.bank = bus.opl3_reg_wr.bank_num;
            p.addr = bus.opl3_reg_wr.address;
            p.data = bus.opl3_reg_wr.data;
            p.cyc  = cyc;
            obs_q.push_back(p);
        end
    end

    always @(negedge clk) begin
        pulse_t p;
        if (bus1.opl3_reg_wr.valid === 1'b1) begin
            p.bank = bus1.opl3_reg_wr.bank_num;
            p.addr = bus1.opl3_reg_wr.address;
            p.data = bus1.opl3_reg_wr.data;
            p.cyc  = cyc;
            obs1_q.push_back(p);
        end
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic push_exp(input logic [0:0] b, input logic [7:0] a, input logic [7:0] d);
        wr_t e;
        e.bank = b;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic host_wr(input logic [1:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        bus.host_valid = 1'b1;
        bus.host_addr  = a;
        bus.host_data  = d;
    endtask

    task automatic host_wr1(input logic [1:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        bus1.host_valid = 1'b1;
        bus1.host_addr  = a;
        bus1.host_data  = d;
    endtask

    task automatic host_idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bus.host_valid  = 1'b0;
            bus1.host_valid = 1'b0;
        end
    endtask

    // Wait (bounded) for every outstanding expected write to appear, allow a
    // quiet period for stray pulses, then compare in order. Pulse cycles of
    // the compared writes are left in pc_q.
    task automatic drain(input string tag, input bit sel);
        int     budget;
        int     nexp;
        int     nobs;
        pulse_t p;
        wr_t    e;
        budget = 0;
        nexp   = exp_q.size() - exp_rd;
        while (budget < 400) begin
            nobs = sel ? (obs1_q.size() - obs1_rd) : (obs_q.size() - obs_rd);
            if (nobs >= nexp) break;
            @(posedge clk);
            budget++;
        end
        repeat (12) @(posedge clk);
        #1;
        nobs = sel ? (obs1_q.size() - obs1_rd) : (obs_q.size() - obs_rd);
        check($sformatf("%s_count", tag), nobs, nexp);
        pc_q.delete();
        for (int i = 0; i < nexp && i < nobs; i++) begin
            p = sel ? obs1_q[obs1_rd + i] : obs_q[obs_rd + i];
            e = exp_q[exp_rd + i];
            check($sformatf("%s_wr%0d", tag, i), {p.bank, p.addr, p.data}, e);
            pc_q.push_back(p.cyc);
        end
        exp_rd = exp_q.size();
        if (sel) obs1_rd = obs1_q.size();
        else     obs_rd  = obs_q.size();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        logic rdy [13];

        bus.host_valid  = 1'b0;
        bus.host_addr   = 2'd0;
        bus.host_data   = 8'd0;
        bus1.host_valid = 1'b0;
        bus1.host_addr  = 2'd0;
        bus1.host_data  = 8'd0;
        reset = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", bus.host_ready, 1'b0);
        check("rst_overflow", bus.overflow, 1'b0);
        check("rst_reg_wr", bus.opl3_reg_wr, '0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("ready_after_rst", bus.host_ready, 1'b1);
        check("ready1_after_rst", bus1.host_ready, 1'b1);

        // Data write with no prior address write
        host_wr(2'd1, 8'h5A);
        n = cyc;
        push_exp(1'b0, 8'h00, 8'h5A);
        host_idle(1);
        drain("no_addr", 1'b0);
        check("no_addr_latency", pc_q[0], n + 2);

        // Bank 0 address then data
        host_wr(2'd0, 8'hB3);
        host_wr(2'd1, 8'h20);
        n = cyc;
        push_exp(1'b0, 8'hB3, 8'h20);
        host_idle(1);
        drain("bank0", 1'b0);
        check("bank0_latency", pc_q[0], n + 2);
        check("hold_fields", bus.opl3_reg_wr, {1'b0, 1'b0, 8'hB3, 8'h20});

        // Bank 1 address, data via port 3 then port 1 (bank from latch)
        host_wr(2'd2, 8'h05);
        host_wr(2'd3, 8'h01);
        push_exp(1'b1, 8'h05, 8'h01);
        host_wr(2'd1, 8'h7F);
        push_exp(1'b1, 8'h05, 8'h7F);
        host_idle(1);
        drain("bank1", 1'b0);
        check("bank1_spacing", pc_q[1] - pc_q[0], 4);

        // Back-to-back burst: with pops at k+1, k+5, k+9, writes 0..10 fit
        // and writes 11 and 12 find the FIFO full.
        host_wr(2'd0, 8'h40);
        for (int i = 0; i < 13; i++) begin
            host_wr(2'd1, 8'h10 + 8'(i));
            if (i == 0) n = cyc;
            if (i <= 10) push_exp(1'b0, 8'h40, 8'h10 + 8'(i));
            #2;
            rdy[i] = bus.host_ready;
        end
        host_idle(1);
        check("burst_ready_w10", rdy[10], 1'b1);
        check("burst_ready_w11", rdy[11], 1'b0);
        check("burst_ready_w12", rdy[12], 1'b0);
        check("burst_overflow", bus.overflow, 1'b1);
        drain("burst", 1'b0);
        check("burst_latency", pc_q[0], n + 2);
        for (int j = 1; j < 11; j++) begin
            check($sformatf("burst_spacing%0d", j), pc_q[j] - pc_q[j-1], 4);
        end
`ifdef OPL3_HOST_WR_BRIDGE_STATS_EN
        check("stats_drop_count", drop_count, 8'd2);
        check("stats_wr_count", wr_count, 16'(exp_q.size()));
`endif

        // Reset while 5 entries are buffered and the FSM sits in GAP
        host_wr(2'd2, 8'h33);
        for (int i = 0; i < 7; i++) begin
            host_wr(2'd1, 8'hC0 + 8'(i));
            if (i < 2) push_exp(1'b1, 8'h33, 8'hC0 + 8'(i));
        end
        @(posedge clk); #1;
        bus.host_valid = 1'b0;
        check("pre_rst_overflow_sticky", bus.overflow, 1'b1);
        reset = 1'b1;
        #1;
        check("mid_rst_valid", bus.opl3_reg_wr.valid, 1'b0);
        check("mid_rst_reg_wr", bus.opl3_reg_wr, '0);
        check("mid_rst_overflow", bus.overflow, 1'b0);
        check("mid_rst_ready", bus.host_ready, 1'b0);
`ifdef OPL3_HOST_WR_BRIDGE_STATS_EN
        check("mid_rst_wr_count", wr_count, 16'd0);
        check("mid_rst_drop_count", drop_count, 8'd0);
`endif
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        host_idle(30);
        drain("rst_mid", 1'b0);
        check("post_rst_ready", bus.host_ready, 1'b1);
        check("post_rst_overflow", bus.overflow, 1'b0);

        // MIN_WR_GAP=1 instance: three queued writes issue on consecutive cycles
        host_wr1(2'd0, 8'h40);
        host_wr1(2'd1, 8'hA1);
        n = cyc;
        push_exp(1'b0, 8'h40, 8'hA1);
        host_wr1(2'd1, 8'hA2);
        push_exp(1'b0, 8'h40, 8'hA2);
        host_wr1(2'd1, 8'hA3);
        push_exp(1'b0, 8'h40, 8'hA3);
        host_idle(1);
        drain("gap1", 1'b1);
        check("gap1_pulse0", pc_q[0], n + 2);
        check("gap1_pulse1", pc_q[1], n + 3);
        check("gap1_pulse2", pc_q[2], n + 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
